// File: rtl/ps2_scancode_parser.sv
// ps2_scancode_parser: pops raw Set-2 bytes from the ps2_keyboard FIFO, folds the
// E0/F0 prefixes into one key event per keystroke, filters auto-repeat, tracks the
// held key and counts distinct presses. Events leave on a valid/ready handshake.
module ps2_scancode_parser #(
    parameter int unsigned CNT_W     = 8,
    parameter bit          REPEAT_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             hold_valid,
    output logic [7:0]       hold_code,
    output logic             hold_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err,
    input  logic             err_clr
);
    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] B_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] B_BRK = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t             state_q;
    logic               pop_q;
    logic [BYTE_W-1:0]  byte_q;
    logic               evt_valid_q;
    logic [BYTE_W-1:0]  evt_code_q;
    logic               evt_ext_q;
    logic               evt_break_q;
    logic               evt_repeat_q;
    logic               hold_valid_q;
    logic [BYTE_W-1:0]  hold_code_q;
    logic               hold_ext_q;
    logic [CNT_W-1:0]   press_cnt_q;
    logic               err_q;

    logic               pop_go;
    logic               cur_ext;
    logic               cur_brk;
    logic               is_ign;
    logic               is_bad;
    logic               hold_match;
    logic               err_d;

    // Byte classification, prefix flags of the current state and pop eligibility
    always_comb begin
        pop_go     = kbd_ready && (state_q != S_EMIT) && !pop_q;
        cur_ext    = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        cur_brk    = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        is_ign     = (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                     (byte_q == 8'hFE) || (byte_q == 8'hEE);
        is_bad     = (byte_q == 8'h00) || (byte_q == 8'hFF);
        hold_match = hold_valid_q && (hold_code_q == byte_q) && (hold_ext_q == cur_ext);
        err_d      = kbd_overflow || (pop_q && is_bad) || (err_q && !err_clr);
    end

    // Pop/latch, prefix FSM, event handshake, held key and press counter
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pop_q        <= 1'b0;
            byte_q       <= '0;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            evt_repeat_q <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_code_q  <= '0;
            hold_ext_q   <= 1'b0;
            press_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            pop_q <= pop_go;
            err_q <= err_d;
            if (pop_go) begin
                byte_q <= kbd_data;
            end
            if (state_q == S_EMIT) begin
                if (evt_ready) begin
                    evt_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            end else if (pop_q) begin
                if (byte_q == B_EXT) begin
                    if (state_q == S_IDLE) begin
                        state_q <= S_EXT;
                    end else if (state_q == S_BRK) begin
                        state_q <= S_EXT_BRK;
                    end
                end else if (byte_q == B_BRK) begin
                    if (state_q == S_IDLE) begin
                        state_q <= S_BRK;
                    end else if (state_q == S_EXT) begin
                        state_q <= S_EXT_BRK;
                    end
                end else if (is_bad) begin
                    state_q <= S_IDLE;
                end else if (!is_ign) begin
                    if (!cur_brk && hold_match && !REPEAT_EN) begin
                        // Typematic repeat of the held key is swallowed
                        state_q <= S_IDLE;
                    end else begin
                        state_q      <= S_EMIT;
                        evt_valid_q  <= 1'b1;
                        evt_code_q   <= byte_q;
                        evt_ext_q    <= cur_ext;
                        evt_break_q  <= cur_brk;
                        evt_repeat_q <= !cur_brk && hold_match;
                        if (cur_brk) begin
                            if (hold_match) begin
                                hold_valid_q <= 1'b0;
                            end
                        end else if (!hold_match) begin
                            hold_valid_q <= 1'b1;
                            hold_code_q  <= byte_q;
                            hold_ext_q   <= cur_ext;
                            press_cnt_q  <= press_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign nextdata_n = !pop_q;
    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_ext    = evt_ext_q;
    assign evt_break  = evt_break_q;
    assign evt_repeat = evt_repeat_q;
    assign hold_valid = hold_valid_q;
    assign hold_code  = hold_code_q;
    assign hold_ext   = hold_ext_q;
    assign press_cnt  = press_cnt_q;
    assign err        = err_q;

endmodule
